mmio_axi_master: RTL and testbench

- Initiator end of the 5-channel MMIO bus (AR/R/AW/W/B) whose responder is the DPI-backed MMIO slave.
- Sits between the LSU (memory stage) and the MMIO slave.
- Converts one LSU load/store request at a time into bus transactions and returns one response pulse with the extended load data or a write status.
- Blocking, single-outstanding design: no new request is accepted until the current response has been issued.

---
 rtl/mmio_axi_master.sv | 173 +++++++++++++++++
 tb/tb_mmio_axi_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_axi_master.sv
// Blocking, single-outstanding LSU-to-MMIO initiator driving the AR/R/AW/W/B channels.
// Define MMIO_AXI_MASTER_TIMEOUT_EN to build the per-transaction watchdog (TIMEOUT_CYCLES).
module mmio_axi_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] arAddr,
  output logic [31:0] arWidth,
  output logic        arValid,
  input  logic        arReady,
  input  logic [31:0] rData,
  input  logic        rValid,
  output logic        rReady,
  output logic [31:0] awAddr,
  output logic [1:0]  awPort,
  output logic        awValid,
  input  logic        awReady,
  output logic [31:0] wData,
  output logic [3:0]  wStrb,
  output logic        wValid,
  input  logic        wReady,
  input  logic [1:0]  bResp,
  input  logic        bValid,
  output logic        bReady
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, rd_ext;
  logic [1:0]  size_q;
  logic [2:0]  width_q, width_d;
  logic        uns_q, aw_done, w_done;
  logic        accept, aw_fire, w_fire, wr_done, timeout;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Valids/readies decode from registered state only, so none depends on its partner.
  assign arValid   = (state == RD_ADDR);
  assign rReady    = (state == RD_DATA);
  assign awValid   = (state == WR_REQ) && !aw_done;
  assign wValid    = (state == WR_REQ) && !w_done;
  assign bReady    = (state == WR_RESP);
  assign rsp_valid = (state == RESP);

  assign arAddr  = addr_q;
  assign awAddr  = addr_q;
  assign awPort  = 2'b00;
  assign arWidth = {29'd0, width_q};
  assign wData   = wdata_q;

  assign aw_fire = awValid && awReady;
  assign w_fire  = wValid && wReady;
  assign wr_done = (aw_done || aw_fire) && (w_done || w_fire);

  always_comb begin
    width_d = 3'd4;
    case (req_size)
      2'b00:   width_d = 3'd1;
      2'b01:   width_d = 3'd2;
      default: width_d = 3'd4;
    endcase
  end

  // Strobes stay LSB-aligned; the slave interprets awAddr itself.
  always_comb begin
    wStrb = 4'b1111;
    case (size_q)
      2'b00:   wStrb = 4'b0001;
      2'b01:   wStrb = 4'b0011;
      default: wStrb = 4'b1111;
    endcase
  end

  always_comb begin
    rd_ext = rData;
    case (size_q)
      2'b00:   rd_ext = uns_q ? {24'd0, rData[7:0]}  : {{24{rData[7]}}, rData[7:0]};
      2'b01:   rd_ext = uns_q ? {16'd0, rData[15:0]} : {{16{rData[15]}}, rData[15:0]};
      default: rd_ext = rData;
    endcase
  end

`ifdef MMIO_AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             busy;

  assign busy    = state inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP};
  assign timeout = busy && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)       to_cnt <= '0;
    else if (accept) to_cnt <= '0;
    else if (busy)   to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (req_size == 2'b11) state_next = RESP;
        else if (req_wen)      state_next = WR_REQ;
        else                   state_next = RD_ADDR;
      end
      RD_ADDR: if (arReady) state_next = RD_DATA;
      RD_DATA: if (rValid)  state_next = RESP;
      WR_REQ:  if (wr_done) state_next = WR_RESP;
      WR_RESP: if (bValid)  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = RESP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      width_q   <= '0;
      uns_q     <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        size_q    <= req_size;
        width_q   <= width_d;
        uns_q     <= req_unsigned;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= (req_size == 2'b11);
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (state == RD_DATA && rValid) rsp_rdata <= rd_ext;
      if (state == WR_RESP && bValid) rsp_err   <= (bResp != 2'b00);
      // Watchdog expiry overrides anything captured in the same cycle.
      if (timeout) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_axi_master.sv
// Self-checking bench for mmio_axi_master: scripted bus slave plus an expected-response scoreboard.
module tb_mmio_axi_master;

  logic        clk, reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] arAddr, arWidth, rData, awAddr, wData;
  logic        arValid, arReady, rValid, rReady;
  logic [1:0]  awPort, bResp;
  logic        awValid, awReady, wValid, wReady, bValid, bReady;
  logic [3:0]  wStrb;

  mmio_axi_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arAddr(arAddr), .arWidth(arWidth), .arValid(arValid), .arReady(arReady),
    .rData(rData), .rValid(rValid), .rReady(rReady),
    .awAddr(awAddr), .awPort(awPort), .awValid(awValid), .awReady(awReady),
    .wData(wData), .wStrb(wStrb), .wValid(wValid), .wReady(wReady),
    .bResp(bResp), .bValid(bValid), .bReady(bReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Observations recorded by run_txn; cycle numbering counts the accept cycle as cycle 1.
  logic        got, o_err, saw_ar, saw_aw, saw_w, aw_unstable, o_arv;
  logic [31:0] o_rdata, o_width, o_araddr, o_wdata;
  logic [3:0]  o_strb;
  int          lat, aw_cycles;

  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] sz, input logic u);
    logic [31:0] r;
    r = d;
    if (sz == 2'b00) r = u ? (d & 32'hFF)   : ((d & 32'hFF)   | (d[7]  ? 32'hFFFF_FF00 : 32'h0));
    if (sz == 2'b01) r = u ? (d & 32'hFFFF) : ((d & 32'hFFFF) | (d[15] ? 32'hFFFF_0000 : 32'h0));
    return r;
  endfunction

  // Issues one request and plays the slave with the given per-channel wait states.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [31:0] rd,
                         input logic [1:0] bresp, input int ar_dly, input int aw_dly,
                         input int w_dly, input int b_dly);
    int   ar_n, aw_n, w_n, b_n, wt;
    logic ar_vp, r_rp, aw_vp, w_vp, b_rp, aw_f, w_f, b_f;
    logic [31:0] aw0;
    ar_n = 0; aw_n = 0; w_n = 0; b_n = 0; wt = 0;
    ar_vp = 0; r_rp = 0; aw_vp = 0; w_vp = 0; b_rp = 0; aw_f = 0; w_f = 0; b_f = 0; aw0 = 0;
    got = 0; o_err = 0; saw_ar = 0; saw_aw = 0; saw_w = 0; aw_unstable = 0; o_arv = 0;
    o_rdata = 0; o_width = 0; o_araddr = 0; o_wdata = 0; o_strb = 0; lat = 0; aw_cycles = 0;
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    #1;
    while (!req_ready && wt < 50) begin @(negedge clk); #1; wt++; end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_accept: req_ready=%b required 1", req_ready);
      req_valid = 0; return;
    end
    @(posedge clk);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      req_valid = 0;
      if (rsp_valid) begin
        got = 1; lat = k + 1; o_rdata = rsp_rdata; o_err = rsp_err; o_arv = arValid;
        break;
      end
      if (r_rp && rValid) rValid = 0;
      if (ar_vp && arReady) begin rValid = 1; rData = rd; end
      if (aw_vp && awReady) aw_f = 1;
      if (w_vp && wReady) w_f = 1;
      if (b_rp && bValid) begin bValid = 0; b_f = 1; end
      else if (aw_f && w_f && !b_f) begin
        b_n++;
        if (b_n > b_dly) begin bValid = 1; bResp = bresp; end
      end
      if (arValid) begin
        if (!saw_ar) begin o_width = arWidth; o_araddr = arAddr; end
        saw_ar = 1; ar_n++; arReady = (ar_n > ar_dly);
      end else arReady = 0;
      if (awValid) begin
        if (!saw_aw) aw0 = awAddr;
        else if (awAddr !== aw0) aw_unstable = 1;
        saw_aw = 1; aw_cycles++; aw_n++; awReady = (aw_n > aw_dly);
      end else awReady = 0;
      if (wValid) begin
        saw_w = 1; o_strb = wStrb; o_wdata = wData; w_n++; wReady = (w_n > w_dly);
      end else wReady = 0;
      ar_vp = arValid; r_rp = rReady; aw_vp = awValid; w_vp = wValid; b_rp = bReady;
    end
    arReady = 0; rValid = 0; awReady = 0; wReady = 0; bValid = 0; bResp = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_tests++;
    if ({arValid, awValid, wValid, rReady, bReady, rsp_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_valids: got %b want 000000", {arValid, awValid, wValid, rReady, bReady, rsp_valid});
    end
    reset = 0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    n_tests++;
    if ({arAddr, awAddr, wData, arWidth, rsp_rdata, rsp_err} !== '0) begin
      n_fail++; $display("FAIL reset_regs: arAddr=%h awAddr=%h wData=%h arWidth=%0d rdata=%h err=%b want all 0",
                         arAddr, awAddr, wData, arWidth, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_load_word;
    sb.push_back('{rdata: 32'h8765_4321, err: 1'b0, cyc: 4});
    run_txn(0, 32'hA000_0048, 0, 2'b10, 0, 32'h8765_4321, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL load_word rsp: none within bound"); end
    n_tests++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL load_word rdata: got %h want %h", o_rdata, e.rdata); end
    n_tests++; if (o_err !== e.err) begin n_fail++; $display("FAIL load_word err: got %b want %b", o_err, e.err); end
    n_tests++; if (lat != e.cyc) begin n_fail++; $display("FAIL load_word latency: got %0d want %0d", lat, e.cyc); end
    n_tests++; if (o_width !== 32'd4) begin n_fail++; $display("FAIL load_word arWidth: got %0d want 4", o_width); end
    n_tests++; if (o_araddr !== 32'hA000_0048) begin n_fail++; $display("FAIL load_word arAddr: got %h want a0000048", o_araddr); end
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL load_word pulse: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_load_ext;
    logic [31:0] rd [4];
    logic [1:0]  sz [4];
    logic        un [4];
    logic [31:0] wd [4];
    rd = '{32'h0000_0080, 32'h0000_0080, 32'hABCD_8001, 32'h1234_5680};
    sz = '{2'b00, 2'b00, 2'b01, 2'b00};
    un = '{1'b0, 1'b1, 1'b0, 1'b1};
    wd = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_0080};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rdata: wd[i], err: 1'b0, cyc: 4});
      run_txn(0, 32'hA000_0100 + 32'(i), 0, sz[i], un[i], rd[i], 0, 0, 0, 0, 0);
      e = sb.pop_front();
      n_tests++;
      if (got !== 1'b1 || o_rdata !== e.rdata || o_err !== e.err) begin
        n_fail++; $display("FAIL load_ext[%0d]: got rsp=%b rdata=%h err=%b want rdata=%h err=%b", i, got, o_rdata, o_err, e.rdata, e.err);
      end
      n_tests++;
      if (o_width !== ((sz[i] == 2'b00) ? 32'd1 : 32'd2)) begin
        n_fail++; $display("FAIL load_ext[%0d] arWidth: got %0d", i, o_width);
      end
    end
  endtask

  task automatic test_store_half;
    sb.push_back('{rdata: 32'h0, err: 1'b0, cyc: 9});
    run_txn(1, 32'hA000_0200, 32'h1234_BEEF, 2'b01, 0, 0, 2'b00, 0, 3, 0, 2);
    e = sb.pop_front();
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL store_half rsp: none within bound"); end
    n_tests++; if (o_strb !== 4'b0011) begin n_fail++; $display("FAIL store_half wStrb: got %b want 0011", o_strb); end
    n_tests++; if (o_wdata !== 32'h1234_BEEF) begin n_fail++; $display("FAIL store_half wData: got %h want 1234beef", o_wdata); end
    n_tests++; if (aw_cycles != 4 || aw_unstable) begin n_fail++; $display("FAIL store_half awValid hold: cycles=%0d unstable=%b want 4/0", aw_cycles, aw_unstable); end
    n_tests++; if (o_err !== e.err || o_rdata !== e.rdata) begin n_fail++; $display("FAIL store_half rsp: err=%b rdata=%h want %b/%h", o_err, o_rdata, e.err, e.rdata); end
    n_tests++; if (lat != e.cyc) begin n_fail++; $display("FAIL store_half latency: got %0d want %0d", lat, e.cyc); end
  endtask

  task automatic test_store_err;
    // Word store: W accepted after AW, slave errors.
    sb.push_back('{rdata: 32'h0, err: 1'b1, cyc: 6});
    run_txn(1, 32'hA000_0300, 32'hCAFE_F00D, 2'b10, 0, 0, 2'b10, 0, 0, 2, 0);
    e = sb.pop_front();
    n_tests++; if (got !== 1'b1 || o_err !== e.err) begin n_fail++; $display("FAIL store_err bresp10: rsp=%b err=%b want 1/%b", got, o_err, e.err); end
    n_tests++; if (o_strb !== 4'b1111) begin n_fail++; $display("FAIL store_err wStrb: got %b want 1111", o_strb); end
    n_tests++; if (lat != e.cyc) begin n_fail++; $display("FAIL store_err latency: got %0d want %0d", lat, e.cyc); end
    // Byte store with same-cycle AW/W completion, zero wait states.
    sb.push_back('{rdata: 32'h0, err: 1'b1, cyc: 4});
    run_txn(1, 32'hA000_0303, 32'h0000_00A5, 2'b00, 0, 0, 2'b01, 0, 0, 0, 0);
    e = sb.pop_front();
    n_tests++; if (got !== 1'b1 || o_err !== e.err || lat != e.cyc) begin n_fail++; $display("FAIL store_err byte: rsp=%b err=%b lat=%0d want 1/%b/%0d", got, o_err, lat, e.err, e.cyc); end
    n_tests++; if (o_strb !== 4'b0001) begin n_fail++; $display("FAIL store_err byte wStrb: got %b want 0001", o_strb); end
  endtask

  task automatic test_illegal;
    sb.push_back('{rdata: 32'h0, err: 1'b1, cyc: 2});
    run_txn(0, 32'hA000_0400, 0, 2'b11, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_tests++; if (got !== 1'b1 || o_err !== e.err || o_rdata !== e.rdata) begin n_fail++; $display("FAIL illegal rsp: rsp=%b err=%b rdata=%h want 1/%b/%h", got, o_err, o_rdata, e.err, e.rdata); end
    n_tests++; if ({saw_ar, saw_aw, saw_w} !== 3'b000) begin n_fail++; $display("FAIL illegal bus: ar/aw/w seen=%b want 000", {saw_ar, saw_aw, saw_w}); end
    n_tests++; if (lat != e.cyc) begin n_fail++; $display("FAIL illegal latency: got %0d want %0d", lat, e.cyc); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_addr = 32'hA000_0500; req_size = 2'b10; req_unsigned = 0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid accept: req_ready=%b want 1", req_ready); end
    @(negedge clk); req_valid = 0; arReady = 1;
    @(negedge clk); arReady = 0;
    n_tests++; if (rReady !== 1'b1) begin n_fail++; $display("FAIL reset_mid rd_data: rReady=%b want 1", rReady); end
    reset = 1;
    @(negedge clk); reset = 0; #1;
    n_tests++;
    if ({arValid, rReady, req_ready, rsp_valid} !== 4'b0010) begin
      n_fail++; $display("FAIL reset_mid state: arValid=%b rReady=%b req_ready=%b rsp_valid=%b want 0/0/1/0", arValid, rReady, req_ready, rsp_valid);
    end
    seen = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen = 1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid spurious rsp: seen=%b want 0", seen); end
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, cyc: 4});
    run_txn(0, 32'hA000_0504, 0, 2'b10, 0, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_tests++; if (got !== 1'b1 || o_rdata !== e.rdata || lat != e.cyc) begin n_fail++; $display("FAIL reset_mid next load: rsp=%b rdata=%h lat=%0d want 1/%h/%0d", got, o_rdata, lat, e.rdata, e.cyc); end
  endtask

  task automatic test_back_to_back;
    logic        wen, uns;
    logic [1:0]  sz;
    logic [31:0] rd, wd;
    int          ad, awd, wdl, bd, mx;
    for (int i = 0; i < 8; i++) begin
      wen = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2)); rd = $urandom; wd = $urandom;
      ad = $urandom_range(0, 2); awd = $urandom_range(0, 2); wdl = $urandom_range(0, 2); bd = $urandom_range(0, 2);
      mx = (awd > wdl) ? awd : wdl;
      if (wen) sb.push_back('{rdata: 32'h0, err: 1'b0, cyc: 4 + mx + bd});
      else     sb.push_back('{rdata: ext(rd, sz, uns), err: 1'b0, cyc: 4 + ad});
      run_txn(wen, 32'hA000_1000 + 32'(i * 4), wd, sz, uns, rd, 2'b00, ad, awd, wdl, bd);
      e = sb.pop_front();
      n_tests++;
      if (got !== 1'b1 || o_rdata !== e.rdata || o_err !== e.err || lat != e.cyc) begin
        n_fail++; $display("FAIL b2b[%0d] wen=%b sz=%0d: rsp=%b rdata=%h err=%b lat=%0d want %h/%b/%0d",
                           i, wen, sz, got, o_rdata, o_err, lat, e.rdata, e.err, e.cyc);
      end
      if (wen) begin
        n_tests++;
        if (o_wdata !== wd) begin n_fail++; $display("FAIL b2b[%0d] wData: got %h want %h", i, o_wdata, wd); end
      end
    end
  endtask

`ifdef MMIO_AXI_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    sb.push_back('{rdata: 32'h0, err: 1'b1, cyc: 18});
    run_txn(0, 32'hA000_2000, 0, 2'b10, 0, 32'h1111_1111, 0, 1000, 0, 0, 0);
    e = sb.pop_front();
    n_tests++; if (got !== 1'b1 || o_err !== e.err || o_rdata !== e.rdata) begin n_fail++; $display("FAIL timeout rsp: rsp=%b err=%b rdata=%h want 1/%b/%h", got, o_err, o_rdata, e.err, e.rdata); end
    n_tests++; if (lat != e.cyc) begin n_fail++; $display("FAIL timeout latency: got %0d want %0d", lat, e.cyc); end
    n_tests++; if (o_arv !== 1'b0) begin n_fail++; $display("FAIL timeout arValid: got %b want 0", o_arv); end
  endtask
`endif

  initial begin
    reset = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    arReady = 0; rData = 0; rValid = 0; awReady = 0; wReady = 0; bResp = 0; bValid = 0;
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_half();
    test_store_err();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
`ifdef MMIO_AXI_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
